// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC select and optional return-address stack
// Define PC_UNIT_RAS_EN to build the RAS; without it CALL acts as JUMP and RET as SEQ.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               STEP         = 4,
   parameter int               RAS_DEPTH    = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           enable,
   input  logic [2:0]                     sel,
   input  logic [WIDTH-1:0]               offset,
   input  logic [WIDTH-1:0]               target,
   output logic [WIDTH-1:0]               pc,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_overflow,
   output logic                           ras_underflow
);

   localparam logic [2:0] SEL_BRANCH = 3'd1;
   localparam logic [2:0] SEL_JUMP   = 3'd2;
   localparam logic [2:0] SEL_CALL   = 3'd3;
   localparam logic [2:0] SEL_RET    = 3'd4;

   logic [WIDTH-1:0] pc_seq;
   logic [WIDTH-1:0] pc_next;

   assign pc_seq = pc + WIDTH'(STEP);

`ifdef PC_UNIT_RAS_EN
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [WIDTH-1:0] ras [RAS_DEPTH];
   logic [PW-1:0]    top;   // next free slot; top-1 holds the newest entry
   logic             ras_full;
   logic             ras_empty;
   logic             do_push;
   logic             do_pop;
   logic             do_underflow;

   assign ras_full     = (ras_count == CW'(RAS_DEPTH));
   assign ras_empty    = (ras_count == '0);
   assign do_push      = enable && (sel == SEL_CALL);
   assign do_pop       = enable && (sel == SEL_RET) && !ras_empty;
   assign do_underflow = enable && (sel == SEL_RET) && ras_empty;

   always_comb begin
      pc_next = pc_seq;
      case (sel)
         SEL_BRANCH: pc_next = pc + offset;
         SEL_JUMP,
         SEL_CALL:   pc_next = target;
         SEL_RET:    if (!ras_empty) pc_next = ras[top - PW'(1)];
         default:    pc_next = pc_seq;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) ras[top] <= pc_seq;
   end

   // A push onto a full stack lands on the oldest slot since the pointer wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top           <= '0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         if (do_push) begin
            top <= top + PW'(1);
            if (ras_full) ras_overflow <= 1'b1;
            else          ras_count    <= ras_count + CW'(1);
         end
         if (do_pop) begin
            top       <= top - PW'(1);
            ras_count <= ras_count - CW'(1);
         end
         if (do_underflow) ras_underflow <= 1'b1;
      end
   end
`else
   always_comb begin
      pc_next = pc_seq;
      case (sel)
         SEL_BRANCH: pc_next = pc + offset;
         SEL_JUMP,
         SEL_CALL:   pc_next = target;
         default:    pc_next = pc_seq;
      endcase
   end

   assign ras_count     = '0;
   assign ras_overflow  = 1'b0;
   assign ras_underflow = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         pc <= RESET_VECTOR;
      else if (enable) pc <= pc_next;
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit (both PC_UNIT_RAS_EN builds)
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
   localparam bit RAS_ON = 1'b1;
`else
   localparam bit RAS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [2:0]  sel;
   logic [31:0] offset;
   logic [31:0] target;
   logic [31:0] pc;
   logic [3:0]  ras_count;
   logic        ras_overflow;
   logic        ras_underflow;

   int total = 0;
   int bad   = 0;

   pc_unit dut (
      .clk(clk), .rst(rst), .enable(enable), .sel(sel), .offset(offset), .target(target),
      .pc(pc), .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [2:0]  sel;
      logic [31:0] off;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t tbl [13];

   // reference model: RAS as a bounded queue, newest at the back
   logic [31:0] m_pc;
   logic [31:0] m_q [$];
   logic        m_ovf;
   logic        m_unf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [31:0] e_pc, input int e_cnt,
                            input logic e_ovf, input logic e_unf);
      check({name, ".pc"}, pc, e_pc);
      check({name, ".cnt"}, 32'(ras_count), 32'(e_cnt));
      check({name, ".ovf"}, 32'(ras_overflow), 32'(e_ovf));
      check({name, ".unf"}, 32'(ras_underflow), 32'(e_unf));
   endtask

   task automatic step(input logic e, input logic [2:0] s, input logic [31:0] o, input logic [31:0] t);
      enable = e; sel = s; offset = o; target = t;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   task automatic model_step(input logic e, input logic [2:0] s, input logic [31:0] o, input logic [31:0] t);
      if (!e) return;
      case (s)
         3'd1: m_pc = m_pc + o;
         3'd2: m_pc = t;
         3'd3: begin
            if (RAS_ON) begin
               if (m_q.size() == 8) begin
                  void'(m_q.pop_front());
                  m_ovf = 1'b1;
               end
               m_q.push_back(m_pc + 32'd4);
            end
            m_pc = t;
         end
         3'd4: begin
            if (RAS_ON && m_q.size() > 0) m_pc = m_q.pop_back();
            else begin
               if (RAS_ON) m_unf = 1'b1;
               m_pc = m_pc + 32'd4;
            end
         end
         default: m_pc = m_pc + 32'd4;
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] pushed [9];
      rst = 1'b1; enable = 1'b0; sel = 3'd0; offset = '0; target = '0;
      #12;
      check_all("reset", 32'h0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      tbl[0]  = '{1'b1, 3'd0, 32'h0, 32'h0, 32'h4};
      tbl[1]  = '{1'b1, 3'd0, 32'h0, 32'h0, 32'h8};
      tbl[2]  = '{1'b1, 3'd0, 32'h0, 32'h0, 32'hC};
      tbl[3]  = '{1'b0, 3'd2, 32'h0, 32'h100, 32'hC};
      tbl[4]  = '{1'b1, 3'd2, 32'h0, 32'h40, 32'h40};
      tbl[5]  = '{1'b1, 3'd1, 32'hFFFF_FFF8, 32'h0, 32'h38};
      tbl[6]  = '{1'b1, 3'd2, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
      tbl[7]  = '{1'b1, 3'd0, 32'h0, 32'h0, 32'h0};
      tbl[8]  = '{1'b1, 3'd5, 32'h0, 32'h500, 32'h4};
      tbl[9]  = '{1'b1, 3'd7, 32'h0, 32'h700, 32'h8};
      tbl[10] = '{1'b1, 3'd1, 32'h10, 32'h0, 32'h18};
      tbl[11] = '{1'b0, 3'd1, 32'h10, 32'h0, 32'h18};
      tbl[12] = '{1'b1, 3'd2, 32'h0, 32'h10, 32'h10};

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].en, tbl[i].sel, tbl[i].off, tbl[i].tgt);
         check_all($sformatf("vec%0d", i), tbl[i].exp_pc, 0, 1'b0, 1'b0);
      end

`ifdef PC_UNIT_RAS_EN
      step(1'b1, 3'd3, 32'h0, 32'h200);
      check_all("call", 32'h200, 1, 1'b0, 1'b0);
      step(1'b1, 3'd4, 32'h0, 32'h0);
      check_all("ret", 32'h14, 0, 1'b0, 1'b0);

      pushed[0] = 32'h18;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) pushed[i] = 32'h1000 + 32'(i - 1) * 32'h100 + 32'h4;
         step(1'b1, 3'd3, 32'h0, 32'h1000 + 32'(i) * 32'h100);
      end
      check_all("ovf", 32'h1800, 8, 1'b1, 1'b0);
      for (int i = 8; i >= 1; i--) begin
         step(1'b1, 3'd4, 32'h0, 32'h0);
         check($sformatf("pop%0d", i), pc, pushed[i]);
      end
      check("popcnt", 32'(ras_count), 32'd0);
      step(1'b1, 3'd4, 32'h0, 32'h0);
      check_all("unf", 32'h1008, 0, 1'b1, 1'b1);
      step(1'b0, 3'd3, 32'h0, 32'h3000);
      check_all("stall_call", 32'h1008, 0, 1'b1, 1'b1);

      for (int i = 0; i < 3; i++) step(1'b1, 3'd3, 32'h0, 32'h2000 + 32'(i) * 32'h10);
      check("pre_rst.cnt", 32'(ras_count), 32'd3);
`else
      step(1'b1, 3'd3, 32'h0, 32'h80);
      check_all("call", 32'h80, 0, 1'b0, 1'b0);
      step(1'b1, 3'd4, 32'h0, 32'h0);
      check_all("ret", 32'h84, 0, 1'b0, 1'b0);
      step(1'b1, 3'd4, 32'h0, 32'h0);
      check_all("ret2", 32'h88, 0, 1'b0, 1'b0);
`endif

      #2;
      rst = 1'b1;
      #1;
      check_all("async_rst", 32'h0, 0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 3'd2, 32'h0, 32'h60);
      check_all("post_rst", 32'h60, 0, 1'b0, 1'b0);

      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic        e;
         logic [2:0]  s;
         logic [31:0] o;
         logic [31:0] t;
         int          so;
         e  = ($urandom_range(0, 9) != 0);
         s  = 3'($urandom_range(0, 7));
         so = int'($urandom_range(0, 63));
         o  = 32'((so - 32) * 4);
         t  = $urandom & 32'hFFFF_FFFC;
         step(e, s, o, t);
         model_step(e, s, o, t);
         check_all($sformatf("rnd%0d", n), m_pc, RAS_ON ? m_q.size() : 0, m_ovf, m_unf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit that succeeds the single-register PC. It holds the fetch address and computes the next address from a per-cycle select: sequential step, PC-relative branch, absolute jump, call and return. An optional return-address stack (RAS) supports call/return. The block sits at the head of the fetch stage, driven by the control unit's next-PC select and stall.

## Interface
Parameters:
- WIDTH, 32, address width in bits
- RESET_VECTOR, 0, value loaded into `pc` on reset
- STEP, 4, sequential increment in bytes
- RAS_DEPTH, 8, return-address stack entries (power of two, ≥2)

Ports:
- clk  in  1  clock, rising edge active
- rst  in  1  asynchronous, active-high reset
- enable  in  1  update PC this cycle; low = stall (full hold)
- sel  in  3  next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 CALL, 4 RET, 5–7 treated as SEQ
- offset  in  WIDTH  signed two's-complement branch displacement
- target  in  WIDTH  absolute jump/call target
- pc  out  WIDTH  current fetch address (registered)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- ras_overflow  out  1  sticky: a CALL pushed onto a full RAS
- ras_underflow  out  1  sticky: a RET popped an empty RAS

## Operation
- Reset (asynchronous, immediate): `pc` = RESET_VECTOR, `ras_count` = 0, both sticky flags = 0. RAS contents are don't-care.
- `enable` low: `pc`, RAS, `ras_count` and flags all hold, whatever `sel` is.
- `enable` high, per `sel`:
  - SEQ: `pc` ← `pc` + STEP.
  - BRANCH: `pc` ← `pc` + `offset`.
  - JUMP: `pc` ← `target`.
  - CALL: push `pc` + STEP, then `pc` ← `target`.
  - RET: pop the top entry into `pc`.
- All arithmetic is modulo 2^WIDTH.
  - Wrap-around is silent.
  - `pc` = 2^WIDTH − STEP under SEQ yields 0.
- RAS is a circular LIFO with a top pointer.
  - CALL with `ras_count` < RAS_DEPTH: write entry, advance pointer, increment count.
  - CALL with `ras_count` = RAS_DEPTH: overwrite the oldest entry (pointer still advances), count stays RAS_DEPTH, set `ras_overflow`.
  - RET with `ras_count` > 0: `pc` ← top entry, retreat pointer, decrement count.
  - RET with `ras_count` = 0: `pc` ← `pc` + STEP (falls through as SEQ), pointer and count unchanged, set `ras_underflow`.
- Sticky flags clear only on reset.

## Timing
- Single-cycle latency: inputs sampled at a rising edge are reflected in `pc` and `ras_count` immediately after that edge.
- No combinational path from inputs to outputs; all outputs are registered.
- A pushed entry is poppable on the very next enabled cycle (CALL then RET returns to caller + STEP).
- Reset asserted mid-sequence: outputs take reset values asynchronously. The first edge after deassertion applies normal operation using the current inputs.
- RAS storage is a register array; no read latency.

## Configuration
- Macro `PC_UNIT_RAS_EN`.
- Defined: RAS, `ras_count` and sticky flags behave as above.
- Undefined: no RAS storage is built.
  - CALL behaves exactly as JUMP.
  - RET behaves exactly as SEQ.
  - `ras_count`, `ras_overflow` and `ras_underflow` are tied to 0.
  - RAS_DEPTH is ignored.

## Test plan
- Reset/SEQ/stall: rst, then 3 cycles SEQ with `enable`=1 → `pc` = 0, 4, 8, 0xC; then `enable`=0 with `sel`=JUMP, `target`=0x100 → `pc` holds 0xC.
- Branch/jump/wrap: `pc`=0x40, BRANCH `offset`=−8 → 0x38; JUMP `target`=0xFFFF_FFFC, then SEQ → 0x0000_0000.
- Call/return: `pc`=0x10, CALL `target`=0x200 → `pc`=0x200 and `ras_count`=1; RET → `pc`=0x14 and `ras_count`=0.
- Overflow (RAS_DEPTH=8): 9 CALLs from distinct PCs → `ras_count`=8 and `ras_overflow`=1; 8 RETs return the newest 8 addresses in reverse order; the 9th RET sets `ras_underflow`=1 and steps `pc` by 4.
- Async reset mid-run: `ras_count`=3, assert rst between edges → `pc`=RESET_VECTOR, `ras_count`=0, both flags 0 before the next edge.
- Macro off: CALL `target`=0x80 → `pc`=0x80 and `ras_count`=0; RET → `pc`=0x84.
